// File: rtl/mem_bus_arbiter.sv
// Arbiter for the shared external memory port between icache refills and dcache refill/write-back.
// Optional round-robin tie-break enabled by defining MEM_ARB_ROUND_ROBIN_EN; default is fixed dcache priority.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                i_valid_q, i_valid_d;
  logic                d_valid_q, d_valid_d;
  logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;
  logic                grant_d_c;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // High when the icache won the most recent grant; reset value lets dcache win the first tie.
  logic rr_last_i_q, rr_last_i_d;

  assign grant_d_c = d_req && (!i_req || rr_last_i_q);

  always_comb begin
    rr_last_i_d = rr_last_i_q;
    if ((state_q == IDLE) && (i_req || d_req)) begin
      rr_last_i_d = !grant_d_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last_i_q <= 1'b1;
    end else begin
      rr_last_i_q <= rr_last_i_d;
    end
  end
`else
  assign grant_d_c = d_req;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_valid_q   <= i_valid_d;
      d_valid_q   <= d_valid_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          mem_req_d = 1'b1;
          if (grant_d_c) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            state_d     = BUSY_D;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = i_addr;
            state_d    = BUSY_I;
          end
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          i_rdata_d = mem_rdata;
          i_valid_d = 1'b1;
          state_d   = RESP_I;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          // Write-backs leave the last refilled line in place.
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
          d_valid_d = 1'b1;
          state_d   = RESP_D;
        end
      end
      RESP_I, RESP_D: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_valid   = i_valid_q;
  assign d_valid   = d_valid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
